// File: rtl/uart_tx_stream_arbiter_pkg.sv
// Shared definitions for the UART TX stream arbiter.
// Holds the stream byte width, the largest supported requester count,
// the arbiter state encoding and a helper that sizes saturating counters.
package uart_tx_stream_arbiter_pkg;

  localparam int STREAM_W    = 8;
  localparam int NUM_REQ_MAX = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Bits needed to hold 0..v inclusive.
  // A zero limit still gets one bit so counters never collapse to zero width.
  function automatic int cnt_width(input int v);
    return (v < 1) ? 1 : $clog2(v + 1);
  endfunction

endpackage

// File: rtl/uart_tx_stream_arbiter_picker.sv
// rr_priority_picker: combinational round-robin search.
// Scans req starting at last+1 and wrapping modulo N.
// The index 'last' itself is checked last, so it ends up with the lowest priority.
// Ports:
//   req      in  N  request vector
//   last     in  W  index of the previous winner
//   next_idx out W  first requesting index after last (equals last if none)
//   found    out 1  high when any request is present
module rr_priority_picker #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] next_idx,
  output logic         found
);

  int idx;

  always_comb begin
    found    = 1'b0;
    next_idx = last;
    idx      = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        next_idx = W'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_stream_arbiter.sv
// uart_tx_stream_arbiter: shares one 8-bit AXI-Stream byte path into the UART TX among NUM_REQ sources.
// A grant is held for a whole packet. It is released when any of these happens:
//   - a handshake with tlast
//   - MAX_BURST bytes have been sent
//   - an idle timeout expires
//   - enable drops
// Ports:
//   PCLK, PRESETn    clock, synchronous active-low reset
//   enable           arbitration enable (low drops the current grant)
//   s_tvalid/s_tready/s_tdata/s_tlast   per-requester slave streams
//   m_tvalid/m_tready/m_tdata           master stream towards the UART TX
//   grant_id         current or last granted requester
//   grant_active     high while a grant is held
module uart_tx_stream_arbiter
  import uart_tx_stream_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int MAX_BURST    = 64,
  parameter int IDLE_TIMEOUT = 256
) (
  input  logic                          PCLK,
  input  logic                          PRESETn,
  input  logic                          enable,
  input  logic [NUM_REQ-1:0]            s_tvalid,
  output logic [NUM_REQ-1:0]            s_tready,
  input  logic [STREAM_W*NUM_REQ-1:0]   s_tdata,
  input  logic [NUM_REQ-1:0]            s_tlast,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic [STREAM_W-1:0]           m_tdata,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          grant_active
);

  localparam int GW        = $clog2(NUM_REQ);
  localparam int BW        = cnt_width(MAX_BURST);
  localparam int IW        = cnt_width(IDLE_TIMEOUT);
  localparam int BURST_SAT = MAX_BURST;
  localparam int IDLE_SAT  = (IDLE_TIMEOUT == 0) ? ((1 << IW) - 1) : IDLE_TIMEOUT;

  arb_state_e      state, state_next;
  logic [GW-1:0]   grant_next, pick_idx;
  logic            pick_found;
  logic [BW-1:0]   burst_cnt, burst_next;
  logic [IW-1:0]   idle_cnt, idle_next;
  logic            sel_valid, sel_last, handshake;
  logic            burst_hit, idle_hit;

  rr_priority_picker #(.N(NUM_REQ), .W(GW)) u_picker (
    .req      (s_tvalid),
    .last     (grant_id),
    .next_idx (pick_idx),
    .found    (pick_found)
  );

  assign grant_active = (state == ST_GRANT);
  assign sel_valid    = s_tvalid[grant_id];
  assign sel_last     = s_tlast[grant_id];
  assign handshake    = m_tvalid & m_tready;

  // A handshake that would make the count equal MAX_BURST releases on that same edge.
  assign burst_hit = handshake && ((int'(burst_cnt) + 1) == MAX_BURST);

  // Only cycles where the granted source has nothing to offer count as idle.
  // A stalled but valid source does not count.
  assign idle_hit  = (IDLE_TIMEOUT != 0) && grant_active && !sel_valid &&
                     ((int'(idle_cnt) + 1) == IDLE_TIMEOUT);

  // Zero-latency output mux. Everything reads as zero unless a grant is held.
  always_comb begin
    m_tvalid = 1'b0;
    m_tdata  = '0;
    s_tready = '0;
    if (grant_active) begin
      m_tvalid           = sel_valid;
      m_tdata            = s_tdata[STREAM_W*int'(grant_id) +: STREAM_W];
      s_tready[grant_id] = m_tready;
    end
  end

  always_comb begin
    state_next = state;
    grant_next = grant_id;
    burst_next = burst_cnt;
    idle_next  = idle_cnt;
    case (state)
      ST_IDLE: begin
        if (enable && pick_found) begin
          state_next = ST_GRANT;
          grant_next = pick_idx;
          burst_next = '0;
          idle_next  = '0;
        end
      end
      ST_GRANT: begin
        if (handshake) begin
          if (int'(burst_cnt) < BURST_SAT) burst_next = burst_cnt + 1'b1;
          idle_next = '0;
        end else if (!sel_valid && (int'(idle_cnt) < IDLE_SAT)) begin
          idle_next = idle_cnt + 1'b1;
        end
        // Dropping enable wins, but a byte handshaking on this edge still completes.
        if (!enable || (handshake && sel_last) || burst_hit || idle_hit)
          state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // grant_id resets to the top index so that requester 0 is searched first.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state     <= ST_IDLE;
      grant_id  <= GW'(NUM_REQ - 1);
      burst_cnt <= '0;
      idle_cnt  <= '0;
    end else begin
      state     <= state_next;
      grant_id  <= grant_next;
      burst_cnt <= burst_next;
      idle_cnt  <= idle_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_stream_arbiter.sv
// Directed self-checking bench for uart_tx_stream_arbiter.
// Parameters: NUM_REQ=4, MAX_BURST=4, IDLE_TIMEOUT=8.
// Inputs change on the falling edge and outputs are checked 1 ns later.
// All expected values are hand-derived.
module tb_uart_tx_stream_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [3:0]  s_tvalid;
  logic [3:0]  s_tready;
  logic [31:0] s_tdata;
  logic [3:0]  s_tlast;
  logic        m_tvalid;
  logic        m_tready;
  logic [7:0]  m_tdata;
  logic [1:0]  grant_id;
  logic        grant_active;

  int checks   = 0;
  int failures = 0;

  uart_tx_stream_arbiter #(
    .NUM_REQ(4), .MAX_BURST(4), .IDLE_TIMEOUT(8)
  ) dut (
    .PCLK         (clk),
    .PRESETn      (rst_n),
    .enable       (enable),
    .s_tvalid     (s_tvalid),
    .s_tready     (s_tready),
    .s_tdata      (s_tdata),
    .s_tlast      (s_tlast),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .m_tdata      (m_tdata),
    .grant_id     (grant_id),
    .grant_active (grant_active)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks that no grant is held and all outputs are zero, then advances to the next falling edge.
  task automatic expect_idle(input string tag, input int exp_g);
    #1;
    check_output({tag, "_active"}, 32'(grant_active), 32'd0);
    check_output({tag, "_gid"},    32'(grant_id),     32'(exp_g));
    check_output({tag, "_mvalid"}, 32'(m_tvalid),     32'd0);
    check_output({tag, "_sready"}, 32'(s_tready),     32'd0);
    check_output({tag, "_mdata"},  32'(m_tdata),      32'd0);
    @(negedge clk);
  endtask

  // Requester r presents n bytes (base, base+1, ...) while m_tready=1.
  // Each byte must pass straight through.
  task automatic stream_bytes(input string tag, input int r, input logic [7:0] base,
                              input int n, input bit last_end);
    for (int b = 0; b < n; b++) begin
      s_tdata[8*r +: 8] = base + 8'(b);
      s_tlast[r]        = last_end && (b == n - 1);
      #1;
      check_output($sformatf("%s_b%0d_active", tag, b), 32'(grant_active), 32'd1);
      check_output($sformatf("%s_b%0d_gid", tag, b),    32'(grant_id),     32'(r));
      check_output($sformatf("%s_b%0d_mvalid", tag, b), 32'(m_tvalid),     32'd1);
      check_output($sformatf("%s_b%0d_mdata", tag, b),  32'(m_tdata),      32'(base + 8'(b)));
      check_output($sformatf("%s_b%0d_sready", tag, b), 32'(s_tready),     32'(4'b0001 << r));
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    enable   = 1'b0;
    s_tvalid = '0;
    s_tdata  = 32'h1313_1212;
    s_tlast  = '0;
    m_tready = 1'b0;

    // Reset state: no grant, grant_id at the top index, outputs zero.
    repeat (2) @(negedge clk);
    #1;
    check_output("rst_active", 32'(grant_active), 32'd0);
    check_output("rst_gid",    32'(grant_id),     32'd3);
    check_output("rst_mvalid", 32'(m_tvalid),     32'd0);
    check_output("rst_sready", 32'(s_tready),     32'd0);
    check_output("rst_mdata",  32'(m_tdata),      32'd0);

    // 1: requester 0 sends a 3-byte packet.
    rst_n       = 1'b1;
    enable      = 1'b1;
    m_tready    = 1'b1;
    s_tvalid[0] = 1'b1;
    expect_idle("t1_idle", 3);
    stream_bytes("t1", 0, 8'hA1, 3, 1'b1);
    s_tvalid[0] = 1'b0;
    s_tlast[0]  = 1'b0;
    expect_idle("t1_rel", 0);

    // 2: all four requesters have 1-byte packets.
    // Expect rotation 1,2,3,0 with a bubble before each grant.
    s_tvalid = 4'b1111;
    s_tlast  = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      expect_idle($sformatf("t2_bub%0d", k), k);
      stream_bytes($sformatf("t2_g%0d", k), (k + 1) % 4, 8'h10 + 8'((k + 1) % 4), 1, 1'b1);
    end

    // 3: requester 1 streams 10 bytes without tlast while requester 2 waits.
    // The burst limit splits requester 1's stream.
    s_tvalid = 4'b0110;
    s_tlast  = 4'b0000;
    expect_idle("t3_bub0", 0);
    stream_bytes("t3_r1a", 1, 8'hB0, 4, 1'b0);
    expect_idle("t3_bub1", 1);
    stream_bytes("t3_r2", 2, 8'hC0, 1, 1'b1);
    s_tvalid[2] = 1'b0;
    s_tlast[2]  = 1'b0;
    expect_idle("t3_bub2", 2);
    stream_bytes("t3_r1b", 1, 8'hB4, 4, 1'b0);
    expect_idle("t3_bub3", 1);
    stream_bytes("t3_r1c", 1, 8'hB8, 2, 1'b1);
    s_tvalid[1] = 1'b0;
    s_tlast[1]  = 1'b0;
    expect_idle("t3_end", 1);

    // 4: requester 0 sends 2 bytes, then goes quiet.
    // The grant is held for exactly 8 idle cycles, then requester 3 wins.
    s_tvalid[0] = 1'b1;
    expect_idle("t4_bub0", 1);
    stream_bytes("t4_r0", 0, 8'hD0, 2, 1'b0);
    s_tvalid[0] = 1'b0;
    s_tvalid[3] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      check_output($sformatf("t4_idle%0d_active", c), 32'(grant_active), 32'd1);
      check_output($sformatf("t4_idle%0d_gid", c),    32'(grant_id),     32'd0);
      check_output($sformatf("t4_idle%0d_mvalid", c), 32'(m_tvalid),     32'd0);
      check_output($sformatf("t4_idle%0d_sready", c), 32'(s_tready),     32'b0001);
      @(negedge clk);
    end
    expect_idle("t4_timeout", 0);
    stream_bytes("t4_r3", 3, 8'hE0, 1, 1'b1);
    s_tvalid[3] = 1'b0;
    s_tlast[3]  = 1'b0;
    expect_idle("t4_end", 3);

    // 5: requester 2 sends a 4-byte packet.
    // First a 10-cycle stall (valid held, so never idle), then m_tready toggles each cycle.
    s_tvalid[2] = 1'b1;
    expect_idle("t5_bub0", 3);
    m_tready           = 1'b0;
    s_tdata[23:16]     = 8'hF0;
    for (int c = 0; c < 10; c++) begin
      #1;
      check_output($sformatf("t5_stall%0d_active", c), 32'(grant_active), 32'd1);
      check_output($sformatf("t5_stall%0d_mvalid", c), 32'(m_tvalid),     32'd1);
      check_output($sformatf("t5_stall%0d_sready", c), 32'(s_tready),     32'd0);
      @(negedge clk);
    end
    begin
      int b;
      b = 0;
      for (int c = 0; c < 8; c++) begin
        m_tready       = c[0];
        s_tdata[23:16] = 8'hF0 + 8'(b);
        s_tlast[2]     = (b == 3);
        #1;
        check_output($sformatf("t5_tog%0d_active", c), 32'(grant_active), 32'd1);
        check_output($sformatf("t5_tog%0d_gid", c),    32'(grant_id),     32'd2);
        check_output($sformatf("t5_tog%0d_mdata", c),  32'(m_tdata),      32'(8'hF0 + 8'(b)));
        check_output($sformatf("t5_tog%0d_sready", c), 32'(s_tready),     c[0] ? 32'b0100 : 32'd0);
        @(negedge clk);
        if (c[0]) b++;
      end
    end
    s_tvalid[2] = 1'b0;
    s_tlast[2]  = 1'b0;
    m_tready    = 1'b1;
    expect_idle("t5_end", 2);

    // 6a: reset in the middle of a packet drops the grant.
    s_tvalid[1] = 1'b1;
    expect_idle("t6_bub0", 2);
    stream_bytes("t6_r1a", 1, 8'h5A, 1, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check_output("t6_rst_active", 32'(grant_active), 32'd0);
    check_output("t6_rst_gid",    32'(grant_id),     32'd3);
    check_output("t6_rst_mvalid", 32'(m_tvalid),     32'd0);
    check_output("t6_rst_sready", 32'(s_tready),     32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    stream_bytes("t6_r1b", 1, 8'h60, 1, 1'b0);

    // 6b: enable drops mid-packet. The byte on that edge still transfers,
    // and arbitration later resumes from grant_id+1.
    enable         = 1'b0;
    s_tvalid       = 4'b0111;
    s_tdata[15:8]  = 8'h61;
    s_tdata[23:16] = 8'h77;
    #1;
    check_output("t6_dis_mvalid", 32'(m_tvalid), 32'd1);
    check_output("t6_dis_mdata",  32'(m_tdata),  32'h61);
    check_output("t6_dis_sready", 32'(s_tready), 32'b0010);
    @(negedge clk);
    expect_idle("t6_drop", 1);
    expect_idle("t6_hold", 1);
    enable = 1'b1;
    expect_idle("t6_reen", 1);
    #1;
    check_output("t6_new_active", 32'(grant_active), 32'd1);
    check_output("t6_new_gid",    32'(grant_id),     32'd2);
    check_output("t6_new_mdata",  32'(m_tdata),      32'h77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
